fcvt_scheduler: RTL and testbench
=================================

FCVT_SCHEDULER -- requirements
Module: fcvt_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one float-to-double converter; legal values 2..8.
REQ-002 Parameter TIMEOUT, default 16, cycles to wait for cvt_done before aborting; legal values 2..255.
REQ-003 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, asynchronous active-low reset.
REQ-005 Port req_valid, input, N_REQ, per-requester conversion request.
REQ-006 Port req_ready, output, N_REQ, per-requester accept; at most one bit high (one-hot or zero).
REQ-007 Port req_float, input, 32*N_REQ, IEEE-754 single operands; requester i occupies bits [32i+31:32i].
REQ-008 Port cvt_start, output, 1, one-cycle start pulse to the converter.
REQ-009 Port cvt_float, output, 32, operand driven to the converter.
REQ-010 Port cvt_done, input, 1, converter result-valid strobe.
REQ-011 Port cvt_double, input, 64, converter result.
REQ-012 Port cvt_nan, input, 1, converter signalling-NaN flag.
REQ-013 Port rsp_valid, output, 1, response available.
REQ-014 Port rsp_ready, input, 1, response consumer accept.
REQ-015 Port rsp_id, output, clog2(N_REQ), index of the requester that owns the response.
REQ-016 Port rsp_double, output, 64, converted value.
REQ-017 Port rsp_nan, output, 1, sNaN exception for this response.
REQ-018 Port rsp_timeout, output, 1, converter failed to answer within TIMEOUT.
REQ-019 Port busy, output, 1, high in every state except IDLE.

Function
REQ-020 The FSM SHALL have exactly the states IDLE, ISSUE, WAIT and RESP.
REQ-021 In IDLE with any req_valid set, req_ready SHALL be asserted combinationally for exactly one requester: the first valid index searching upward, with wrap, from last_grant+1 mod N_REQ.
REQ-022 On the req_valid&req_ready handshake, operand and index SHALL be latched, and the FSM SHALL move to ISSUE.
REQ-023 In ISSUE, cvt_start SHALL be 1 for exactly one cycle, the timeout counter SHALL clear, and the FSM SHALL move to WAIT.
REQ-024 cvt_float SHALL hold the latched operand from ISSUE through the end of WAIT.
REQ-025 In WAIT with cvt_done=1, cvt_double and cvt_nan SHALL be captured, rsp_timeout SHALL be 0, and the FSM SHALL move to RESP.
REQ-026 In WAIT without cvt_done, the counter SHALL increment; when it reaches TIMEOUT-1 it SHALL capture rsp_double=64'h7FF8000000000000, rsp_nan=0 and rsp_timeout=1, then move to RESP.
REQ-027 If cvt_done coincides with the timeout cycle, cvt_done SHALL win.
REQ-028 cvt_done SHALL be ignored in IDLE, ISSUE and RESP.
REQ-029 In RESP, rsp_valid SHALL be 1 and rsp_* SHALL be stable until rsp_ready=1.
REQ-030 On that handshake, last_grant SHALL take rsp_id and the FSM SHALL return to IDLE; no request SHALL be accepted in RESP.
REQ-031 Minimum issue-to-issue spacing SHALL be 4 cycles: IDLE, ISSUE, WAIT, RESP.
REQ-032 Requesters not granted SHALL be allowed to deassert req_valid without effect.

Reset
REQ-033 On reset low, the FSM SHALL asynchronously enter IDLE with last_grant=N_REQ-1 and counter=0.
REQ-034 Also on reset low, req_ready=0, cvt_start=0, cvt_float=0, rsp_valid=0, rsp_id=0, rsp_double=0, rsp_nan=0, rsp_timeout=0 and busy=0.
REQ-035 Reset in mid-operation SHALL discard the in-flight request without a response, and any later cvt_done SHALL be ignored.

Structure
REQ-036 Shared package fpu_pkg SHALL hold the FSM state enum, the constant QNAN64=64'h7FF8000000000000, and the default TIMEOUT.
REQ-037 Round-robin selection SHALL be the sub-module rr_arbiter, with inputs req[N_REQ] and last[clog2] and output grant one-hot.

Verification
REQ-038 After reset, requester 0 sends float 32'h3F800000 and the converter answers in 2 cycles -> cvt_start is one pulse, and the response carries rsp_id=0 and rsp_double=64'h3FF0000000000000.
REQ-039 All four requesters stay valid -> grants go in the order 0,1,2,3,0, with one req_ready per handshake.
REQ-040 A requester sends 32'h7FA00000 and the converter returns cvt_nan=1 -> rsp_nan=1 and rsp_timeout=0.
REQ-041 cvt_done is never asserted -> after exactly TIMEOUT WAIT cycles, rsp_timeout=1 and rsp_double=64'h7FF8000000000000.
REQ-042 rsp_ready is held low for 5 cycles -> rsp_* stay stable and no new req_ready appears.
REQ-043 Reset is asserted during WAIT, then cvt_done arrives -> the block is in IDLE and produces no rsp_valid.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared state encoding and constants for the float-to-double conversion scheduler.
package fpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } fcvt_state_t;

  localparam logic [63:0] QNAN64 = 64'h7FF8_0000_0000_0000;

  localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: grants the first set request searching upward from last+1 with wrap.
// Purely combinational; grant is one-hot, or zero when nothing requests.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last,
  output logic [N_REQ-1:0]         grant
);

  localparam int IDW = $clog2(N_REQ);

  int             pos;
  logic [IDW-1:0] idx;
  logic           found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = 0;
    idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      pos = (int'(last) + k) % N_REQ;
      idx = IDW'(pos);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fcvt_scheduler.sv
// Shares one float-to-double converter among N_REQ requesters: round-robin grant,
// one conversion in flight, converter timeout, and a response held until consumed.
module fcvt_scheduler
  import fpu_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [32*N_REQ-1:0]      req_float,
  output logic                     cvt_start,
  output logic [31:0]              cvt_float,
  input  logic                     cvt_done,
  input  logic [63:0]              cvt_double,
  input  logic                     cvt_nan,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [63:0]              rsp_double,
  output logic                     rsp_nan,
  output logic                     rsp_timeout,
  output logic                     busy
);

  localparam int         IDW      = $clog2(N_REQ);
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  fcvt_state_t    state_q, state_d;
  logic [IDW-1:0] last_q, last_d;
  logic [IDW-1:0] id_q, id_d;
  logic [31:0]    op_q, op_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [63:0]    dbl_q, dbl_d;
  logic           nan_q, nan_d;
  logic           tmo_q, tmo_d;

  logic [N_REQ-1:0] grant;
  logic [IDW-1:0]   grant_idx;
  logic [31:0]      grant_float;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req   (req_valid),
    .last  (last_q),
    .grant (grant)
  );

  always_comb begin
    grant_idx   = '0;
    grant_float = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        grant_idx   = IDW'(i);
        grant_float = req_float[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= IDW'(N_REQ - 1);
      id_q    <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      dbl_q   <= '0;
      nan_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      dbl_q   <= dbl_d;
      nan_q   <= nan_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    dbl_d   = dbl_q;
    nan_d   = nan_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          id_d    = grant_idx;
          op_d    = grant_float;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A result arriving on the last allowed cycle beats the timeout.
        if (cvt_done) begin
          dbl_d   = cvt_double;
          nan_d   = cvt_nan;
          tmo_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          dbl_d   = QNAN64;
          nan_d   = 1'b0;
          tmo_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          last_d  = id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gating with reset keeps req_ready low while reset is held.
  assign req_ready   = (state_q == IDLE && reset) ? grant : '0;
  assign cvt_start   = (state_q == ISSUE);
  assign cvt_float   = op_q;
  assign rsp_valid   = (state_q == RESP);
  assign rsp_id      = id_q;
  assign rsp_double  = dbl_q;
  assign rsp_nan     = nan_q;
  assign rsp_timeout = tmo_q;
  assign busy        = (state_q != IDLE);

  a_ready_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(req_ready));
  a_start_pulse:  assert property (@(posedge clk) disable iff (!reset) cvt_start |=> !cvt_start);

endmodule

// File: tb/tb_fcvt_scheduler.sv
// Directed bench for fcvt_scheduler: a behavioural converter, a cycle-level reference
// model compared every cycle, and literal checks on each directed scenario.
module tb_fcvt_scheduler;

  localparam int          N    = 4;
  localparam int          TMO  = 16;
  localparam logic [63:0] QNAN = 64'h7FF8000000000000;

  localparam int PH_IDLE  = 0;
  localparam int PH_ISSUE = 1;
  localparam int PH_WAIT  = 2;
  localparam int PH_RESP  = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [32*N-1:0] req_float;
  logic            cvt_start;
  logic [31:0]     cvt_float;
  logic            cvt_done;
  logic [63:0]     cvt_double;
  logic            cvt_nan;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [63:0]     rsp_double;
  logic            rsp_nan;
  logic            rsp_timeout;
  logic            busy;

  int checks = 0;
  int errors = 0;

  fcvt_scheduler #(.N_REQ(N), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_float   (req_float),
    .cvt_start   (cvt_start),
    .cvt_float   (cvt_float),
    .cvt_done    (cvt_done),
    .cvt_double  (cvt_double),
    .cvt_nan     (cvt_nan),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_double  (rsp_double),
    .rsp_nan     (rsp_nan),
    .rsp_timeout (rsp_timeout),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-robin expectation: valid index at the smallest circular distance past last.
  function automatic logic [N-1:0] rr_expect(input logic [N-1:0] v, input int last);
    int best;
    int bestd;
    int d;
    best  = -1;
    bestd = N + 1;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        d = (i - last - 1 + 2 * N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    rr_expect = '0;
    if (best >= 0) rr_expect[best] = 1'b1;
  endfunction

  // Converter reference: float -> double for normals, zero and NaN (sNaN quietened, flagged).
  function automatic logic [64:0] f2d(input logic [31:0] f);
    logic [63:0] d;
    logic        n;
    n = 1'b0;
    if (f[30:23] == 8'hFF) begin
      d = {f[31], 11'h7FF, (f[22:0] | ((f[22:0] != 23'h0) ? 23'h400000 : 23'h0)), 29'h0};
      n = (f[22:0] != 23'h0) && !f[22];
    end else if (f[30:0] == 31'h0) begin
      d = {f[31], 63'h0};
    end else begin
      d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'h0};
    end
    f2d = {d, n};
  endfunction

  // Behavioural converter: answers cv_lat cycles after a start pulse; 0 means never.
  int          cv_lat = 0;
  int          cv_cnt = 0;
  bit          cv_pend = 0;
  logic [31:0] cv_op;

  initial begin
    cvt_done   = 1'b0;
    cvt_double = '0;
    cvt_nan    = 1'b0;
    forever begin
      tick();
      cvt_done = 1'b0;
      if (cv_pend) begin
        cv_cnt--;
        if (cv_cnt == 0) begin
          cvt_done              = 1'b1;
          {cvt_double, cvt_nan} = f2d(cv_op);
          cv_pend               = 0;
        end
      end
      if (cvt_start && cv_lat > 0) begin
        cv_pend = 1;
        cv_cnt  = cv_lat;
        cv_op   = cvt_float;
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Reference model state and logs
  int          m_ph = PH_IDLE;
  int          m_last = N - 1;
  int          m_id = 0;
  int          m_wait = 0;
  logic [31:0] m_op = '0;
  logic [63:0] m_dbl = '0;
  logic        m_nan = 1'b0;
  logic        m_tmo = 1'b0;
  logic [N-1:0] exp_rdy;
  int          n_start = 0;
  int          d_wait = 0;
  int          g_log[$];
  int          issue_t[$];
  logic [63:0] r_id[$];
  logic [63:0] r_dbl[$];
  logic [63:0] r_nan[$];
  logic [63:0] r_tmo[$];

  always @(negedge clk) begin
    if (cvt_start) begin
      n_start++;
      d_wait = 0;
    end else if (busy && !rsp_valid) begin
      d_wait++;
    end
    if (!reset) begin
      m_ph   = PH_IDLE;
      m_last = N - 1;
      chk("rst_req_ready", 64'(req_ready), 64'h0);
      chk("rst_cvt_start", 64'(cvt_start), 64'h0);
      chk("rst_cvt_float", 64'(cvt_float), 64'h0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
      chk("rst_rsp_id", 64'(rsp_id), 64'h0);
      chk("rst_rsp_double", rsp_double, 64'h0);
      chk("rst_rsp_nan", 64'(rsp_nan), 64'h0);
      chk("rst_rsp_timeout", 64'(rsp_timeout), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
    end else begin
      case (m_ph)
        PH_IDLE: begin
          exp_rdy = rr_expect(req_valid, m_last);
          chk("idle_req_ready", 64'(req_ready), 64'(exp_rdy));
          chk("idle_busy", 64'(busy), 64'h0);
          chk("idle_cvt_start", 64'(cvt_start), 64'h0);
          chk("idle_rsp_valid", 64'(rsp_valid), 64'h0);
          if (exp_rdy != '0) begin
            for (int i = 0; i < N; i++) begin
              if (exp_rdy[i]) begin
                m_id = i;
                m_op = req_float[32*i +: 32];
              end
            end
            g_log.push_back(m_id);
            m_ph = PH_ISSUE;
          end
        end
        PH_ISSUE: begin
          chk("issue_cvt_start", 64'(cvt_start), 64'h1);
          chk("issue_busy", 64'(busy), 64'h1);
          chk("issue_req_ready", 64'(req_ready), 64'h0);
          chk("issue_rsp_valid", 64'(rsp_valid), 64'h0);
          chk("issue_cvt_float", 64'(cvt_float), 64'(m_op));
          issue_t.push_back(cyc);
          m_wait = 0;
          m_ph   = PH_WAIT;
        end
        PH_WAIT: begin
          chk("wait_cvt_start", 64'(cvt_start), 64'h0);
          chk("wait_busy", 64'(busy), 64'h1);
          chk("wait_req_ready", 64'(req_ready), 64'h0);
          chk("wait_rsp_valid", 64'(rsp_valid), 64'h0);
          chk("wait_cvt_float", 64'(cvt_float), 64'(m_op));
          m_wait++;
          if (cvt_done) begin
            m_dbl = cvt_double;
            m_nan = cvt_nan;
            m_tmo = 1'b0;
            m_ph  = PH_RESP;
          end else if (m_wait == TMO) begin
            m_dbl = QNAN;
            m_nan = 1'b0;
            m_tmo = 1'b1;
            m_ph  = PH_RESP;
          end
        end
        default: begin
          chk("resp_rsp_valid", 64'(rsp_valid), 64'h1);
          chk("resp_busy", 64'(busy), 64'h1);
          chk("resp_req_ready", 64'(req_ready), 64'h0);
          chk("resp_cvt_start", 64'(cvt_start), 64'h0);
          chk("resp_rsp_id", 64'(rsp_id), 64'(m_id));
          chk("resp_rsp_double", rsp_double, m_dbl);
          chk("resp_rsp_nan", 64'(rsp_nan), 64'(m_nan));
          chk("resp_rsp_timeout", 64'(rsp_timeout), 64'(m_tmo));
          if (rsp_ready) begin
            r_id.push_back(64'(rsp_id));
            r_dbl.push_back(rsp_double);
            r_nan.push_back(64'(rsp_nan));
            r_tmo.push_back(64'(rsp_timeout));
            m_last = m_id;
            m_ph   = PH_IDLE;
          end
        end
      endcase
    end
  end

  task automatic send(input int i, input logic [31:0] f);
    bit got;
    got = 0;
    req_float[32*i +: 32] = f;
    req_valid[i] = 1'b1;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (req_ready[i]) got = 1;
    end
    tick();
    req_valid[i] = 1'b0;
    chk("send_granted", 64'(got), 64'h1);
  endtask

  task automatic wait_rsp(input int n);
    for (int k = 0; k < 200 && r_id.size() < n; k++) tick();
    chk("rsp_count", 64'(r_id.size()), 64'(n));
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200 && busy; k++) tick();
    chk("reach_idle", 64'(busy), 64'h0);
  endtask

  int n0;
  int exp_order[5];

  initial begin
    reset     = 1'b0;
    rsp_ready = 1'b1;
    req_float = '0;
    req_valid = 4'b0001;
    req_float[31:0] = 32'h3F800000;
    repeat (3) tick();
    chk("reset_req_ready_held", 64'(req_ready), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    reset = 1'b1;

    // 1.0f, converter answers after 2 cycles
    cv_lat = 2;
    send(0, 32'h3F800000);
    wait_rsp(1);
    chk("t1_rsp_id", r_id[0], 64'h0);
    chk("t1_rsp_double", r_dbl[0], 64'h3FF0000000000000);
    chk("t1_rsp_nan", r_nan[0], 64'h0);
    chk("t1_rsp_timeout", r_tmo[0], 64'h0);
    chk("t1_start_pulses", 64'(n_start), 64'h1);
    chk("t1_wait_cycles", 64'(d_wait), 64'h2);

    // All four requesters held valid from a fresh reset
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    g_log.delete();
    issue_t.delete();
    cv_lat    = 1;
    req_float = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    req_valid = 4'hF;
    for (int k = 0; k < 200 && g_log.size() < 5; k++) tick();
    req_valid = '0;
    wait_idle();
    exp_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) chk("t2_grant_order", 64'(g_log[i]), 64'(exp_order[i]));
    for (int i = 1; i < 5; i++) chk("t2_issue_spacing", 64'(issue_t[i] - issue_t[i-1]), 64'h4);

    // Signalling NaN operand
    n0 = r_id.size();
    cv_lat = 3;
    send(2, 32'h7FA00000);
    wait_rsp(n0 + 1);
    chk("t3_rsp_id", r_id[n0], 64'h2);
    chk("t3_rsp_nan", r_nan[n0], 64'h1);
    chk("t3_rsp_timeout", r_tmo[n0], 64'h0);
    chk("t3_rsp_double", r_dbl[n0], 64'h7FFC000000000000);

    // Converter never answers
    n0 = r_id.size();
    cv_lat = 0;
    send(1, 32'h40490FDB);
    wait_rsp(n0 + 1);
    chk("t4_rsp_timeout", r_tmo[n0], 64'h1);
    chk("t4_rsp_double", r_dbl[n0], QNAN);
    chk("t4_rsp_nan", r_nan[n0], 64'h0);
    chk("t4_wait_cycles", 64'(d_wait), 64'(TMO));

    // Result lands on the timeout cycle itself
    n0 = r_id.size();
    cv_lat = TMO;
    send(0, 32'hC0000000);
    wait_rsp(n0 + 1);
    chk("t5_rsp_timeout", r_tmo[n0], 64'h0);
    chk("t5_rsp_double", r_dbl[n0], 64'hC000000000000000);
    chk("t5_wait_cycles", 64'(d_wait), 64'(TMO));

    // Late result while the response is stalled; another requester waits
    n0 = r_id.size();
    cv_lat    = TMO + 1;
    rsp_ready = 1'b0;
    send(3, 32'h3F800000);
    for (int k = 0; k < 100 && !rsp_valid; k++) tick();
    chk("t6_rsp_valid", 64'(rsp_valid), 64'h1);
    req_valid[0] = 1'b1;
    repeat (5) begin
      tick();
      chk("t6_hold_valid", 64'(rsp_valid), 64'h1);
      chk("t6_hold_req_ready", 64'(req_ready), 64'h0);
      chk("t6_hold_timeout", 64'(rsp_timeout), 64'h1);
      chk("t6_hold_double", rsp_double, QNAN);
      chk("t6_hold_id", 64'(rsp_id), 64'h3);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_rsp(n0 + 1);
    repeat (3) tick();
    chk("t6_no_extra_issue", 64'(busy), 64'h0);

    // Reset while waiting; the late result must be ignored
    n0 = r_id.size();
    cv_lat = 5;
    send(3, 32'h3F800000);
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    repeat (10) tick();
    chk("t7_no_response", 64'(r_id.size()), 64'(n0));
    chk("t7_idle", 64'(busy), 64'h0);
    chk("t7_rsp_valid", 64'(rsp_valid), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
